// File: rtl/raster_pkg.sv
// Shared types and width helpers for the raster position generator.
package raster_pkg;

   // Scan controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width for a range 0..n-1. Never returns less than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter from 0 to MAX. It wraps by comparing against MAX, so a
// range that is not a power of two never reaches the unused codes.
module wrap_counter #(
   parameter int MAX = 3,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] value,
   output logic         at_max
);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   assign at_max = (value_q == W'(MAX));
   assign value  = value_q;

   // Next value: clear wins over increment; increment wraps at MAX.
   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (inc) begin
         value_d = at_max ? '0 : value_q + W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/raster_scan_gen.sv
// Raster position generator. It emits (row, column) over a WIDTH x HEIGHT frame.
// Handshake: valid = (state is RUN) & enable. A position is consumed on a cycle
// where valid & ready. The position advances only on such a cycle, and there is
// no other path that moves it, apart from abort and reset.
module raster_scan_gen
   import raster_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int FCNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         continuous,
   input  logic                         enable,
   input  logic                         ready,
   output logic                         valid,
   output logic [cnt_width(WIDTH)-1:0]  column_counter,
   output logic [cnt_width(HEIGHT)-1:0] row_counter,
   output logic                         sol,
   output logic                         eol,
   output logic                         sof,
   output logic                         eof,
   output logic [FCNT_W-1:0]            frame_count,
   output logic                         busy,
   output logic                         done,
   output state_e                       state_dbg
);

   localparam int CW = cnt_width(WIDTH);
   localparam int RW = cnt_width(HEIGHT);

   state_e              state_q;
   state_e              state_d;
   logic                mode_q;
   logic                mode_d;
   logic [FCNT_W-1:0]   fcnt_q;
   logic [FCNT_W-1:0]   fcnt_d;

   logic                accept;
   logic                col_at_max;
   logic                row_at_max;
   logic                last_pos;
   logic [CW-1:0]       col_val;
   logic [RW-1:0]       row_val;

   assign valid    = (state_q == RUN) && enable;
   assign accept   = valid && ready;
   assign last_pos = col_at_max && row_at_max;

   // The column counter steps on every accepted position.
   wrap_counter #(
      .MAX (WIDTH - 1),
      .W   (CW)
   ) u_col (
      .clk    (clk),
      .rst    (rst),
      .inc    (accept),
      .clear  (abort),
      .value  (col_val),
      .at_max (col_at_max)
   );

   // The row counter steps when an accepted position ends a line.
   wrap_counter #(
      .MAX (HEIGHT - 1),
      .W   (RW)
   ) u_row (
      .clk    (clk),
      .rst    (rst),
      .inc    (accept && col_at_max),
      .clear  (abort),
      .value  (row_val),
      .at_max (row_at_max)
   );

   // Next-state logic. Abort overrides everything. A start pulse is honoured only in IDLE.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = RUN;
                  mode_d  = continuous;
               end
            end
            RUN: begin
               if (accept && last_pos) begin
                  state_d = mode_q ? RUN : DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // The frame counter steps when the last position is accepted, in both modes. Abort holds it.
   always_comb begin
      fcnt_d = fcnt_q;
      if (!abort && accept && last_pos) begin
         fcnt_d = fcnt_q + FCNT_W'(1);
      end
   end

   // Controller registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Boundary flags are qualified by valid, so they drop during a pause.
   always_comb begin
      sol = valid && (col_val == '0);
      eol = valid && col_at_max;
      sof = valid && (col_val == '0) && (row_val == '0);
      eof = valid && last_pos;
   end

   assign column_counter = col_val;
   assign row_counter    = row_val;
   assign frame_count    = fcnt_q;
   assign busy           = (state_q == RUN);
   assign done           = (state_q == DONE);
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Directed bench for raster_scan_gen. It uses a 4x3 instance (A) and a 5x3 instance (B).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_raster_scan_gen;
   import raster_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic start_a    = 1'b0;
   logic start_b    = 1'b0;
   logic abort      = 1'b0;
   logic continuous = 1'b0;
   logic enable     = 1'b0;
   logic ready      = 1'b0;

   logic       valid_a, sol_a, eol_a, sof_a, eof_a, busy_a, done_a;
   logic [1:0] col_a, row_a;
   logic [7:0] fc_a;
   state_e     st_a;

   logic       valid_b, sol_b, eol_b, sof_b, eof_b, busy_b, done_b;
   logic [2:0] col_b;
   logic [1:0] row_b;
   logic [7:0] fc_b;
   state_e     st_b;

   raster_scan_gen #(.WIDTH(4), .HEIGHT(3), .FCNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort), .continuous(continuous),
      .enable(enable), .ready(ready), .valid(valid_a), .column_counter(col_a),
      .row_counter(row_a), .sol(sol_a), .eol(eol_a), .sof(sof_a), .eof(eof_a),
      .frame_count(fc_a), .busy(busy_a), .done(done_a), .state_dbg(st_a)
   );

   raster_scan_gen #(.WIDTH(5), .HEIGHT(3), .FCNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort), .continuous(continuous),
      .enable(enable), .ready(ready), .valid(valid_b), .column_counter(col_b),
      .row_counter(row_b), .sol(sol_b), .eol(eol_b), .sof(sof_b), .eof(eof_b),
      .frame_count(fc_b), .busy(busy_b), .done(done_b), .state_dbg(st_b)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] pk(input int r, input int c);
      logic [7:0] rr;
      logic [7:0] cc;
      rr = r[7:0];
      cc = c[7:0];
      return {rr, cc};
   endfunction

   // Queue the positions with frame indexes first..first+n-1 for a frame of width w and height h.
   task automatic push_pos(input int w, input int h, input int first, input int n);
      for (int k = first; k < first + n; k++) begin
         exp_q.push_back(pk((k % (w * h)) / w, k % w));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic pulse_start_a(input logic cont);
      continuous = cont;
      start_a    = 1'b1;
      nedge();
      start_a    = 1'b0;
   endtask

   // Consume n accepted positions on A against the expected queue.
   task automatic accept_a(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         check({tag, "_valid"}, valid_a, 1'b1);
         check({tag, "_pos"}, pk(int'(row_a), int'(col_a)), exp_q.pop_front());
         nedge();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state, sampled while the reset is held.
      nedge();
      check("rst_valid", valid_a, 1'b0);
      check("rst_pos",   pk(int'(row_a), int'(col_a)), pk(0, 0));
      check("rst_fc",    fc_a, 8'd0);
      check("rst_busy",  busy_a, 1'b0);
      check("rst_done",  done_a, 1'b0);
      check("rst_flags", {sol_a, eol_a, sof_a, eof_a}, 4'b0);
      check("rst_state", st_a, IDLE);
      rst    = 1'b1;
      enable = 1'b1;
      ready  = 1'b1;
      nedge();
      nedge();

      // Single-shot 4x3 frame: 12 valid cycles, then done for one cycle, then IDLE.
      check("t1_idle_valid", valid_a, 1'b0);
      pulse_start_a(1'b0);
      push_pos(4, 3, 0, 12);
      for (int i = 0; i < 12; i++) begin
         check("t1_valid", valid_a, 1'b1);
         check("t1_pos",   pk(int'(row_a), int'(col_a)), exp_q.pop_front());
         check("t1_sof",   sof_a, (i == 0));
         check("t1_eof",   eof_a, (i == 11));
         check("t1_sol",   sol_a, (i % 4 == 0));
         check("t1_eol",   eol_a, (i % 4 == 3));
         check("t1_done0", done_a, 1'b0);
         nedge();
      end
      check("t1_done",     done_a, 1'b1);
      check("t1_dn_state", st_a, DONE);
      check("t1_dn_valid", valid_a, 1'b0);
      check("t1_dn_busy",  busy_a, 1'b0);
      check("t1_dn_fc",    fc_a, 8'd1);
      check("t1_dn_pos",   pk(int'(row_a), int'(col_a)), pk(0, 0));
      nedge();
      check("t1_idle",      st_a, IDLE);
      check("t1_done_drop", done_a, 1'b0);

      // Continuous mode: frames wrap, frame_count keeps counting from 1, done never fires.
      pulse_start_a(1'b1);
      push_pos(4, 3, 0, 36);
      for (int i = 0; i < 36; i++) begin
         if (i % 12 == 0) begin
            check("t2_sof", sof_a, 1'b1);
            check("t2_fc",  fc_a, 8'(1 + i / 12));
         end
         check("t2_nodone", done_a, 1'b0);
         check("t2_pos", pk(int'(row_a), int'(col_a)), exp_q.pop_front());
         nedge();
      end
      check("t2_fc_end", fc_a, 8'd4);
      check("t2_busy",   busy_a, 1'b1);

      // Advance to (1,2), then hold ready low for three cycles.
      push_pos(4, 3, 0, 6);
      accept_a("t3_adv", 6);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nedge();
         check("t3_stall_valid", valid_a, 1'b1);
         check("t3_stall_pos",   pk(int'(row_a), int'(col_a)), pk(1, 2));
      end
      ready = 1'b1;
      nedge();
      check("t3_resume_pos", pk(int'(row_a), int'(col_a)), pk(1, 3));
      check("t3_resume_eol", eol_a, 1'b1);

      // Pause for ten cycles: valid and flags drop, and the position freezes.
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         nedge();
         check("t3_pause_valid", valid_a, 1'b0);
         check("t3_pause_eol",   eol_a, 1'b0);
         check("t3_pause_pos",   pk(int'(row_a), int'(col_a)), pk(1, 3));
      end
      enable = 1'b1;
      #1;
      check("t3_unpause_valid", valid_a, 1'b1);
      check("t3_unpause_pos",   pk(int'(row_a), int'(col_a)), pk(1, 3));
      nedge();
      check("t3_after_pos", pk(int'(row_a), int'(col_a)), pk(2, 0));

      // Move on to (1,0) of the next frame. A start pulse while busy is ignored.
      push_pos(4, 3, 8, 8);
      accept_a("t4_adv", 8);
      check("t4_fc", fc_a, 8'd5);
      start_a = 1'b1;
      nedge();
      start_a = 1'b0;
      check("t4_start_ignored", pk(int'(row_a), int'(col_a)), pk(1, 1));
      check("t4_still_busy",    busy_a, 1'b1);

      // Abort at (1,1): straight to IDLE with the position cleared, frame_count kept, no done.
      abort = 1'b1;
      nedge();
      abort = 1'b0;
      check("t4_abort_state", st_a, IDLE);
      check("t4_abort_valid", valid_a, 1'b0);
      check("t4_abort_pos",   pk(int'(row_a), int'(col_a)), pk(0, 0));
      check("t4_abort_fc",    fc_a, 8'd5);
      check("t4_abort_done",  done_a, 1'b0);
      nedge();
      check("t4_abort_done2", done_a, 1'b0);

      // 5x3 frame: the column runs 0..4 and wraps, with 15 accepts per frame.
      continuous = 1'b0;
      start_b    = 1'b1;
      nedge();
      start_b    = 1'b0;
      push_pos(5, 3, 0, 15);
      for (int i = 0; i < 15; i++) begin
         check("t5_valid", valid_b, 1'b1);
         check("t5_pos",   pk(int'(row_b), int'(col_b)), exp_q.pop_front());
         check("t5_eol",   eol_b, (i % 5 == 4));
         check("t5_eof",   eof_b, (i == 14));
         nedge();
      end
      check("t5_done", done_b, 1'b1);
      check("t5_fc",   fc_b, 8'd1);
      check("t5_pos0", pk(int'(row_b), int'(col_b)), pk(0, 0));
      nedge();

      // Reset asserted between clock edges in the middle of a frame.
      pulse_start_a(1'b0);
      push_pos(4, 3, 0, 3);
      accept_a("t6_adv", 3);
      check("t6_pre_pos", pk(int'(row_a), int'(col_a)), pk(0, 3));
      #2;
      rst = 1'b0;
      #1;
      check("t6_rst_valid", valid_a, 1'b0);
      check("t6_rst_pos",   pk(int'(row_a), int'(col_a)), pk(0, 0));
      check("t6_rst_fc",    fc_a, 8'd0);
      check("t6_rst_busy",  busy_a, 1'b0);
      check("t6_rst_eol",   eol_a, 1'b0);
      check("t6_rst_fcb",   fc_b, 8'd0);
      nedge();
      rst = 1'b1;
      nedge();
      check("t6_rst_done", done_a, 1'b0);
      pulse_start_a(1'b0);
      check("t6_restart_valid", valid_a, 1'b1);
      check("t6_restart_pos",   pk(int'(row_a), int'(col_a)), pk(0, 0));
      check("t6_restart_fc",    fc_a, 8'd0);
      nedge();
      check("t6_restart_pos1",  pk(int'(row_a), int'(col_a)), pk(0, 1));
      abort = 1'b1;
      nedge();
      abort = 1'b0;
      nedge();

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
